riscv_tcm_ram: RTL and testbench
================================

Name: riscv_tcm_ram

Overview:
- 64 KB tightly-coupled memory serving a RISC-V core through two independent ports: a 32-bit instruction-fetch port and a 32-bit data load/store port.
- Built on a true dual-port, byte-addressable RAM with fixed one-cycle response latency on both ports.
- Provides a simulation backdoor task for loading program images before the core leaves reset.

Parameters:
- MEM_ADDR_W, 16, byte-address width (2^16 bytes = 16384 x 32-bit words); only addr[MEM_ADDR_W-1:2] is decoded and upper bits are ignored, so 0x80000000 aliases to word 0.

Ports:
- clk_i  in  1  clock, all state updates on the rising edge
- rst_i  in  1  asynchronous, active-low reset
- mem_i_rd_i  in  1  instruction fetch request
- mem_i_flush_i  in  1  i-cache flush hint; ignored
- mem_i_invalidate_i  in  1  i-cache invalidate hint; ignored
- mem_i_pc_i  in  32  fetch byte address; bits [1:0] ignored
- mem_i_accept_o  out  1  fetch request accepted this cycle
- mem_i_valid_o  out  1  mem_i_inst_o valid
- mem_i_error_o  out  1  fetch error; tied 0
- mem_i_inst_o  out  32  fetched instruction word
- mem_d_addr_i  in  32  data byte address; bits [1:0] ignored
- mem_d_data_wr_i  in  32  store data
- mem_d_rd_i  in  1  load request
- mem_d_wr_i  in  4  per-byte write strobes; bit n writes byte lane n
- mem_d_cacheable_i  in  1  ignored
- mem_d_req_tag_i  in  11  request tag, echoed with the response
- mem_d_invalidate_i  in  1  cache maintenance request; no-op, acknowledged
- mem_d_writeback_i  in  1  cache maintenance request; no-op, acknowledged
- mem_d_flush_i  in  1  cache maintenance request; no-op, acknowledged
- mem_d_data_rd_o  out  32  load data
- mem_d_accept_o  out  1  data request accepted this cycle
- mem_d_ack_o  out  1  response strobe
- mem_d_error_o  out  1  data error; tied 0
- mem_d_resp_tag_o  out  11  tag of the acknowledged request

Behaviour:
- Reset (rst_i low, asynchronous): mem_i_valid_o, mem_i_inst_o, mem_d_ack_o, mem_d_data_rd_o and mem_d_resp_tag_o are 0. RAM contents are not reset.
- Accept: mem_i_accept_o and mem_d_accept_o are combinationally 1, except as modified by the optional feature.
- Fetch: a request is accepted when mem_i_rd_i and mem_i_accept_o are both 1. On the next cycle, mem_i_valid_o=1 and mem_i_inst_o=RAM[pc[15:2]]. Back-to-back fetches give one word per cycle. The flush and invalidate inputs have no effect.
- Data request: "any" = mem_d_rd_i | (|mem_d_wr_i) | mem_d_flush_i | mem_d_invalidate_i | mem_d_writeback_i. A request is accepted when any & mem_d_accept_o.
- Data response: the cycle after acceptance, mem_d_ack_o=1 for exactly one cycle and mem_d_resp_tag_o = the registered req_tag.
- Stores: on acceptance, each byte lane with its strobe set is written at addr[15:2].
- Load data: mem_d_data_rd_o = the word at addr[15:2] as it was before any same-cycle write (read-first). A store-only request returns that old word.
- Maintenance-only requests: acknowledged; mem_d_data_rd_o holds its previous value.
- Read collision: an instruction read and a data write to the same word in the same cycle return the old word to the fetch port. The new word is visible from the next cycle.
- Flow: no internal queueing; one response per accepted request, in order.
- Backdoor: task write(input [31:0] addr, input [7:0] data) writes one byte at addr[MEM_ADDR_W-1:0] with zero delay. It is simulation-only (translate_off) and uses little-endian lane mapping: byte addr[1:0] = lane.

Optional Feature:
- TCM_RANDOM_STALL_EN.
- Defined: a 16-bit Galois LFSR (poly 0xB400, reset seed 0xACE1) advances each cycle. mem_i_accept_o = ~lfsr[0] and mem_d_accept_o = ~lfsr[1]. Unaccepted requests produce no RAM write and no ack; the requester must hold the request.
- Undefined: both accepts are constant 1 and the LFSR is absent.

Decomposition:
- Package riscv_tcm_pkg: MEM_ADDR_W default, TAG_W=11, word width 32, LFSR seed and polynomial constants.
- Sub-module riscv_tcm_ram_dp: true dual-port RAM with port A (instruction) read-only and port B (data) read-first with 4-bit byte write enable. It also hosts the backdoor storage.

Test Plan:
- Reset: hold rst_i low and pulse requests -> all outputs stay 0. Release, then fetch pc=0x80000000 after backdoor word0=0x00000013 -> next cycle mem_i_valid_o=1, mem_i_inst_o=0x00000013.
- Store word: addr=0x80000100, data=0xDEADBEEF, wr=0xF, tag=0x155 -> next cycle ack=1, resp_tag=0x155. A load from the same address then returns 0xDEADBEEF.
- Byte strobes: wr=0x2 with data=0x0000AA00 on the word above -> a subsequent load returns 0xDEADAAEF.
- Back-to-back: loads with tags 1, 2, 3 on consecutive cycles -> acks on three consecutive cycles carrying tags 1, 2, 3 with the correct data.
- Collision: fetch and data store to 0x80000200 (old 0x11111111, new 0x22222222) in the same cycle -> inst=0x11111111; a fetch the next cycle returns 0x22222222.
- With TCM_RANDOM_STALL_EN: 1000 random requests -> ack count equals accepted-request count and memory matches a reference model.

Source files
------------

// File: rtl/riscv_tcm_pkg.sv
// Shared constants for the RISC-V tightly-coupled memory.
// Holds the default byte-address width, bus widths and the stall LFSR constants.
package riscv_tcm_pkg;

    localparam int unsigned MEM_ADDR_W_DEF = 16;
    localparam int unsigned TAG_W          = 11;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BE_W           = WORD_W / 8;
    localparam int unsigned LFSR_W         = 16;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;

    // One step of a right-shifting Galois LFSR.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : LFSR_W'(0));
    endfunction

endpackage

// File: rtl/riscv_tcm_ram_dp.sv
// True dual-port word RAM with a one-cycle registered read on both ports.
// Port A: read-only (instruction side). Port B: read-first with byte write enables.
// Ports: clk_i, rst_i (async active-low, clears the read registers only),
//        a_en_i/a_addr_i/a_rdata_o, b_en_i/b_we_i/b_addr_i/b_wdata_i/b_rdata_o.
// Also hosts the simulation backdoor byte-write task (excluded when SYNTHESIS is defined).
module riscv_tcm_ram_dp
    import riscv_tcm_pkg::*;
#(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              a_en_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    output logic [WORD_W-1:0] a_rdata_o,
    input  logic              b_en_i,
    input  logic [BE_W-1:0]   b_we_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [WORD_W-1:0] b_wdata_i,
    output logic [WORD_W-1:0] b_rdata_o
);

    localparam int unsigned DEPTH = 32'(1) << ADDR_W;

    logic [WORD_W-1:0] ram [DEPTH];

    // Byte-lane writes; contents are never reset.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < int'(BE_W); i++) begin
            if (b_we_i[i]) begin
                ram[b_addr_i][8*i +: 8] <= b_wdata_i[8*i +: 8];
            end
        end
    end

    // Read registers sample the array before this edge's write lands (read-first).
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            a_rdata_o <= '0;
            b_rdata_o <= '0;
        end else begin
            if (a_en_i) a_rdata_o <= ram[a_addr_i];
            if (b_en_i) b_rdata_o <= ram[b_addr_i];
        end
    end

`ifndef SYNTHESIS
    // Backdoor image load: one byte, little-endian lane = addr[1:0].
    task write(input logic [31:0] addr, input logic [7:0] data);
        ram[addr[ADDR_W+1:2]][{addr[1:0], 3'b000} +: 8] <= data;
    endtask
`endif

endmodule

// File: rtl/riscv_tcm_ram.sv
// 64 KB tightly-coupled memory for a RISC-V core: instruction-fetch port and
// data load/store port, each with a fixed one-cycle response.
// Ports: clk_i, rst_i (async active-low); mem_i_* fetch interface; mem_d_* data
//        interface with tag echo; maintenance requests are acknowledged no-ops.
// Option: TCM_RANDOM_STALL_EN gates both accepts with a free-running LFSR.
// Backdoor: task write(addr, data) loads a byte (simulation only).
module riscv_tcm_ram
    import riscv_tcm_pkg::*;
#(
    parameter int unsigned MEM_ADDR_W = MEM_ADDR_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             mem_i_rd_i,
    input  logic             mem_i_flush_i,
    input  logic             mem_i_invalidate_i,
    input  logic [31:0]      mem_i_pc_i,
    output logic             mem_i_accept_o,
    output logic             mem_i_valid_o,
    output logic             mem_i_error_o,
    output logic [31:0]      mem_i_inst_o,
    input  logic [31:0]      mem_d_addr_i,
    input  logic [31:0]      mem_d_data_wr_i,
    input  logic             mem_d_rd_i,
    input  logic [3:0]       mem_d_wr_i,
    input  logic             mem_d_cacheable_i,
    input  logic [TAG_W-1:0] mem_d_req_tag_i,
    input  logic             mem_d_invalidate_i,
    input  logic             mem_d_writeback_i,
    input  logic             mem_d_flush_i,
    output logic [31:0]      mem_d_data_rd_o,
    output logic             mem_d_accept_o,
    output logic             mem_d_ack_o,
    output logic             mem_d_error_o,
    output logic [TAG_W-1:0] mem_d_resp_tag_o
);

    localparam int unsigned WADDR_W = MEM_ADDR_W - 2;

    logic            i_req;
    logic            d_any;
    logic            d_req;
    logic            d_rd_en;
    logic [BE_W-1:0] d_we;

`ifdef TCM_RANDOM_STALL_EN
    logic [LFSR_W-1:0] lfsr_q;

    // Free-running stall pattern.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_next(lfsr_q);
    end

    assign mem_i_accept_o = ~lfsr_q[0];
    assign mem_d_accept_o = ~lfsr_q[1];
`else
    assign mem_i_accept_o = 1'b1;
    assign mem_d_accept_o = 1'b1;
`endif

    assign mem_i_error_o = 1'b0;
    assign mem_d_error_o = 1'b0;

    // Request qualification; the data array only reads for loads and stores so
    // maintenance-only requests leave the load data register untouched.
    assign i_req   = mem_i_rd_i & mem_i_accept_o;
    assign d_any   = mem_d_rd_i | (|mem_d_wr_i) | mem_d_flush_i
                   | mem_d_invalidate_i | mem_d_writeback_i;
    assign d_req   = d_any & mem_d_accept_o;
    assign d_rd_en = d_req & (mem_d_rd_i | (|mem_d_wr_i));
    assign d_we    = d_req ? mem_d_wr_i : '0;

    // Response strobes and tag echo.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_i_valid_o    <= 1'b0;
            mem_d_ack_o      <= 1'b0;
            mem_d_resp_tag_o <= '0;
        end else begin
            mem_i_valid_o <= i_req;
            mem_d_ack_o   <= d_req;
            if (d_req) mem_d_resp_tag_o <= mem_d_req_tag_i;
        end
    end

    riscv_tcm_ram_dp #(
        .ADDR_W (WADDR_W)
    ) u_ram (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .a_en_i    (i_req),
        .a_addr_i  (mem_i_pc_i[MEM_ADDR_W-1:2]),
        .a_rdata_o (mem_i_inst_o),
        .b_en_i    (d_rd_en),
        .b_we_i    (d_we),
        .b_addr_i  (mem_d_addr_i[MEM_ADDR_W-1:2]),
        .b_wdata_i (mem_d_data_wr_i),
        .b_rdata_o (mem_d_data_rd_o)
    );

    // Hint inputs and undecoded address bits are intentionally ignored.
    logic unused_ok;
    assign unused_ok = &{1'b0, mem_i_flush_i, mem_i_invalidate_i, mem_d_cacheable_i,
                         mem_i_pc_i[31:MEM_ADDR_W], mem_i_pc_i[1:0],
                         mem_d_addr_i[31:MEM_ADDR_W], mem_d_addr_i[1:0]};

`ifndef SYNTHESIS
    task write(input logic [31:0] addr, input logic [7:0] data);
        u_ram.write(addr, data);
    endtask
`endif

endmodule

// File: tb/tb_riscv_tcm_ram.sv
// Directed self-checking bench for riscv_tcm_ram (plus a random stall run when
// TCM_RANDOM_STALL_EN is defined).
module tb_riscv_tcm_ram;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_i_rd_i;
    logic        mem_i_flush_i;
    logic        mem_i_invalidate_i;
    logic [31:0] mem_i_pc_i;
    logic        mem_i_accept_o;
    logic        mem_i_valid_o;
    logic        mem_i_error_o;
    logic [31:0] mem_i_inst_o;
    logic [31:0] mem_d_addr_i;
    logic [31:0] mem_d_data_wr_i;
    logic        mem_d_rd_i;
    logic [3:0]  mem_d_wr_i;
    logic        mem_d_cacheable_i;
    logic [10:0] mem_d_req_tag_i;
    logic        mem_d_invalidate_i;
    logic        mem_d_writeback_i;
    logic        mem_d_flush_i;
    logic [31:0] mem_d_data_rd_o;
    logic        mem_d_accept_o;
    logic        mem_d_ack_o;
    logic        mem_d_error_o;
    logic [10:0] mem_d_resp_tag_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    riscv_tcm_ram dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .mem_i_rd_i         (mem_i_rd_i),
        .mem_i_flush_i      (mem_i_flush_i),
        .mem_i_invalidate_i (mem_i_invalidate_i),
        .mem_i_pc_i         (mem_i_pc_i),
        .mem_i_accept_o     (mem_i_accept_o),
        .mem_i_valid_o      (mem_i_valid_o),
        .mem_i_error_o      (mem_i_error_o),
        .mem_i_inst_o       (mem_i_inst_o),
        .mem_d_addr_i       (mem_d_addr_i),
        .mem_d_data_wr_i    (mem_d_data_wr_i),
        .mem_d_rd_i         (mem_d_rd_i),
        .mem_d_wr_i         (mem_d_wr_i),
        .mem_d_cacheable_i  (mem_d_cacheable_i),
        .mem_d_req_tag_i    (mem_d_req_tag_i),
        .mem_d_invalidate_i (mem_d_invalidate_i),
        .mem_d_writeback_i  (mem_d_writeback_i),
        .mem_d_flush_i      (mem_d_flush_i),
        .mem_d_data_rd_o    (mem_d_data_rd_o),
        .mem_d_accept_o     (mem_d_accept_o),
        .mem_d_ack_o        (mem_d_ack_o),
        .mem_d_error_o      (mem_d_error_o),
        .mem_d_resp_tag_o   (mem_d_resp_tag_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        mem_i_rd_i         = 1'b0;
        mem_i_flush_i      = 1'b0;
        mem_i_invalidate_i = 1'b0;
        mem_i_pc_i         = '0;
        mem_d_addr_i       = '0;
        mem_d_data_wr_i    = '0;
        mem_d_rd_i         = 1'b0;
        mem_d_wr_i         = '0;
        mem_d_cacheable_i  = 1'b0;
        mem_d_req_tag_i    = '0;
        mem_d_invalidate_i = 1'b0;
        mem_d_writeback_i  = 1'b0;
        mem_d_flush_i      = 1'b0;
    endtask

    task automatic d_drive(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [10:0] tag);
        mem_d_rd_i      = rd;
        mem_d_wr_i      = wr;
        mem_d_addr_i    = addr;
        mem_d_data_wr_i = data;
        mem_d_req_tag_i = tag;
    endtask

    task automatic bd_word(input logic [31:0] addr, input logic [31:0] word);
        for (int b = 0; b < 4; b++) dut.write(addr + 32'(b), word[8*b +: 8]);
    endtask

    task automatic after_edge();
        @(posedge clk_i);
        #1;
    endtask

`ifdef TCM_RANDOM_STALL_EN
    logic [31:0] model [16];
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        rst_i = 1'b0;

        // Requests during reset must leave every response output at zero.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            mem_i_rd_i = 1'b1;
            mem_i_pc_i = 32'h8000_0F00;
            d_drive(1'b1, 4'hF, 32'h8000_0F00, 32'h1234_5678, 11'h155);
            after_edge();
            check("rst_i_valid", 32'(mem_i_valid_o), 32'd0);
            check("rst_i_inst", mem_i_inst_o, 32'd0);
            check("rst_d_ack", 32'(mem_d_ack_o), 32'd0);
            check("rst_d_data", mem_d_data_rd_o, 32'd0);
            check("rst_d_tag", 32'(mem_d_resp_tag_o), 32'd0);
        end
        @(negedge clk_i);
        idle();

        bd_word(32'h0000_0000, 32'h0000_0013);
        bd_word(32'h0000_0200, 32'h1111_1111);
        bd_word(32'h0000_0300, 32'hA0A0_0001);
        bd_word(32'h0000_0304, 32'hB0B0_0002);
        bd_word(32'h0000_0308, 32'hC0C0_0003);
`ifdef TCM_RANDOM_STALL_EN
        for (int w = 0; w < 16; w++) begin
            model[w] = 32'h5000_0000 + 32'(w * 32'h0101_0101);
            bd_word(32'h400 + 32'(4 * w), model[w]);
        end
`endif
        @(negedge clk_i);
        rst_i = 1'b1;

`ifndef TCM_RANDOM_STALL_EN
        check("err_ties", {30'd0, mem_i_error_o, mem_d_error_o}, 32'd0);

        // Fetch through the aliased base address.
        @(negedge clk_i);
        mem_i_rd_i = 1'b1;
        mem_i_pc_i = 32'h8000_0000;
        after_edge();
        check("fetch0_valid", 32'(mem_i_valid_o), 32'd1);
        check("fetch0_inst", mem_i_inst_o, 32'h0000_0013);

        // Back-to-back fetches, one word per cycle.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            mem_i_pc_i = 32'h8000_0300 + 32'(4 * k);
            after_edge();
            check("fetch_b2b_valid", 32'(mem_i_valid_o), 32'd1);
            check("fetch_b2b_inst", mem_i_inst_o, (k == 0) ? 32'hA0A0_0001 :
                                                  (k == 1) ? 32'hB0B0_0002 : 32'hC0C0_0003);
        end
        @(negedge clk_i);
        mem_i_rd_i = 1'b0;
        after_edge();
        check("fetch_idle_valid", 32'(mem_i_valid_o), 32'd0);

        // Full-word store: acked next cycle with its tag, for exactly one cycle.
        @(negedge clk_i);
        d_drive(1'b0, 4'hF, 32'h8000_0100, 32'hDEAD_BEEF, 11'h155);
        after_edge();
        check("st_ack", 32'(mem_d_ack_o), 32'd1);
        check("st_tag", 32'(mem_d_resp_tag_o), 32'h155);
        @(negedge clk_i);
        idle();
        after_edge();
        check("st_ack_once", 32'(mem_d_ack_o), 32'd0);

        @(negedge clk_i);
        d_drive(1'b1, 4'h0, 32'h8000_0100, 32'h0, 11'h00A);
        after_edge();
        check("ld_ack", 32'(mem_d_ack_o), 32'd1);
        check("ld_tag", 32'(mem_d_resp_tag_o), 32'h00A);
        check("ld_data", mem_d_data_rd_o, 32'hDEAD_BEEF);

        // Single-lane store returns the old word, then the merged word reads back.
        @(negedge clk_i);
        d_drive(1'b0, 4'h2, 32'h8000_0100, 32'h0000_AA00, 11'h00B);
        after_edge();
        check("bst_old_data", mem_d_data_rd_o, 32'hDEAD_BEEF);
        @(negedge clk_i);
        d_drive(1'b1, 4'h0, 32'h8000_0100, 32'h0, 11'h00C);
        after_edge();
        check("bst_merged", mem_d_data_rd_o, 32'hDEAD_AAEF);

        // Maintenance-only request: acked, load data holds.
        @(negedge clk_i);
        idle();
        mem_d_flush_i   = 1'b1;
        mem_d_req_tag_i = 11'h7FF;
        after_edge();
        check("maint_ack", 32'(mem_d_ack_o), 32'd1);
        check("maint_tag", 32'(mem_d_resp_tag_o), 32'h7FF);
        check("maint_hold", mem_d_data_rd_o, 32'hDEAD_AAEF);

        // Back-to-back loads, tags 1..3.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            idle();
            d_drive(1'b1, 4'h0, 32'h8000_0300 + 32'(4 * k), 32'h0, 11'(k + 1));
            after_edge();
            check("b2b_ack", 32'(mem_d_ack_o), 32'd1);
            check("b2b_tag", 32'(mem_d_resp_tag_o), 32'(k + 1));
            check("b2b_data", mem_d_data_rd_o, (k == 0) ? 32'hA0A0_0001 :
                                               (k == 1) ? 32'hB0B0_0002 : 32'hC0C0_0003);
        end

        // Same-word fetch and store in one cycle: fetch sees the old word.
        @(negedge clk_i);
        idle();
        mem_i_rd_i = 1'b1;
        mem_i_pc_i = 32'h8000_0200;
        d_drive(1'b0, 4'hF, 32'h8000_0200, 32'h2222_2222, 11'h005);
        after_edge();
        check("coll_old_inst", mem_i_inst_o, 32'h1111_1111);
        check("coll_ack", 32'(mem_d_ack_o), 32'd1);
        @(negedge clk_i);
        d_drive(1'b0, 4'h0, 32'h0, 32'h0, 11'h0);
        mem_i_pc_i = 32'h0000_0200;
        after_edge();
        check("coll_new_inst", mem_i_inst_o, 32'h2222_2222);
        @(negedge clk_i);
        idle();
`else
        begin
            int          n_acc;
            int          n_ack;
            logic        pending;
            logic        has_data;
            logic [31:0] exp_data;
            logic [31:0] last_rd;
            logic [10:0] exp_tag;
            int          w;
            logic [31:0] nw;
            n_acc    = 0;
            n_ack    = 0;
            pending  = 1'b0;
            last_rd  = 32'd0;
            has_data = 1'b0;
            exp_tag  = '0;
            w        = 0;
            for (int c = 0; c < 1000; c++) begin
                @(negedge clk_i);
                if (!pending) begin
                    idle();
                    w = int'($urandom_range(0, 15));
                    mem_d_addr_i    = 32'h8000_0400 + 32'(4 * w);
                    mem_d_data_wr_i = $urandom;
                    mem_d_req_tag_i = 11'($urandom);
                    case ($urandom_range(0, 3))
                        0: mem_d_rd_i = 1'b1;
                        1: mem_d_wr_i = 4'($urandom_range(1, 15));
                        2: begin mem_d_rd_i = 1'b1; mem_d_wr_i = 4'($urandom_range(1, 15)); end
                        default: mem_d_writeback_i = 1'b1;
                    endcase
                    pending = 1'b1;
                end
                if (mem_d_accept_o) begin
                    n_acc++;
                    pending  = 1'b0;
                    exp_tag  = mem_d_req_tag_i;
                    has_data = mem_d_rd_i | (|mem_d_wr_i);
                    exp_data = has_data ? model[w] : last_rd;
                    nw = model[w];
                    for (int b = 0; b < 4; b++)
                        if (mem_d_wr_i[b]) nw[8*b +: 8] = mem_d_data_wr_i[8*b +: 8];
                    model[w] = nw;
                    after_edge();
                    if (mem_d_ack_o) n_ack++;
                    check("rnd_ack", 32'(mem_d_ack_o), 32'd1);
                    check("rnd_tag", 32'(mem_d_resp_tag_o), 32'(exp_tag));
                    check("rnd_data", mem_d_data_rd_o, exp_data);
                    last_rd = exp_data;
                end else begin
                    after_edge();
                    if (mem_d_ack_o) n_ack++;
                    check("rnd_noack", 32'(mem_d_ack_o), 32'd0);
                end
            end
            check("rnd_ack_count", 32'(n_ack), 32'(n_acc));

            // Final sweep of the touched words against the model.
            for (int k = 0; k < 16; k++) begin
                int waited;
                @(negedge clk_i);
                idle();
                d_drive(1'b1, 4'h0, 32'h8000_0400 + 32'(4 * k), 32'h0, 11'(k));
                waited = 0;
                while (!mem_d_accept_o && waited < 200) begin
                    @(negedge clk_i);
                    waited++;
                end
                if (!mem_d_accept_o) check("sweep_timeout", 32'd0, 32'd1);
                after_edge();
                check("sweep_data", mem_d_data_rd_o, model[k]);
            end
            @(negedge clk_i);
            idle();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
